// File: rtl/instr_loader.sv
// Debug-unit instruction loader: assembles MSB-first UART bytes into 32-bit words
// and writes them into instruction memory until a sentinel word, overflow or timeout.
module instr_loader #(
    parameter int          MEM_DEPTH      = 32,
    parameter int          START_ADDR     = 0,
    parameter logic [31:0] END_WORD       = 32'hFFFF_FFFF,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        wr_instruction,
    output logic [31:0] data_instruction,
    output logic [31:0] wr_addr,
    output logic [5:0]  words_loaded,
    output logic        busy,
    output logic        load_done,
    output logic        load_error
);
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERROR} state_t;

    state_t        r_state;
    logic [31:0]   r_acc;
    logic [1:0]    r_byte_cnt;
    logic [TW-1:0] r_to_cnt;
    logic          r_pend;

    logic [31:0] w_word;
    logic [31:0] w_cand;
    logic        w_last;
    logic        w_complete;
    logic        w_full;
    logic        w_idle;

    assign w_word     = {r_acc[23:0], rx_data};
    assign w_last     = rx_valid && (r_byte_cnt == 2'd3);
    // A word finished during WRITE sits in r_acc and is judged in the next RECV cycle
    assign w_cand     = r_pend ? r_acc : w_word;
    assign w_complete = (r_state == S_RECV) && (r_pend || w_last);
    assign w_full     = {26'd0, words_loaded} == 32'(MEM_DEPTH);
    assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_acc            <= '0;
            r_byte_cnt       <= '0;
            r_to_cnt         <= '0;
            r_pend           <= 1'b0;
            wr_instruction   <= 1'b0;
            data_instruction <= '0;
            wr_addr          <= '0;
            words_loaded     <= '0;
            busy             <= 1'b0;
            load_done        <= 1'b0;
            load_error       <= 1'b0;
        end else begin
            wr_instruction <= 1'b0;
            if (w_idle) begin
                if (start) begin
                    r_state      <= S_RECV;
                    r_acc        <= '0;
                    r_byte_cnt   <= '0;
                    r_to_cnt     <= '0;
                    r_pend       <= 1'b0;
                    wr_addr      <= 32'(START_ADDR);
                    words_loaded <= '0;
                    busy         <= 1'b1;
                    load_done    <= 1'b0;
                    load_error   <= 1'b0;
                end
            end else begin
                if (rx_valid) begin
                    r_acc      <= w_word;
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end
                // Timeout only guards the gap inside a partially assembled word
                if (rx_valid || r_byte_cnt == 2'd0)
                    r_to_cnt <= '0;
                else if (r_state == S_RECV)
                    r_to_cnt <= r_to_cnt + 1'b1;

                if (r_state == S_WRITE) begin
                    wr_addr      <= wr_addr + 32'd1;
                    words_loaded <= words_loaded + 6'd1;
                    r_state      <= S_RECV;
                    if (w_last)
                        r_pend <= 1'b1;
                end else if (w_complete) begin
                    r_pend <= 1'b0;
                    if (w_cand == END_WORD) begin
                        r_state   <= S_DONE;
                        load_done <= 1'b1;
                        busy      <= 1'b0;
                    end else if (w_full) begin
                        r_state    <= S_ERROR;
                        load_error <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        data_instruction <= w_cand;
                        wr_instruction   <= 1'b1;
                        r_state          <= S_WRITE;
                    end
                end else if (!rx_valid && r_byte_cnt != 2'd0 && r_to_cnt == TO_LAST) begin
                    r_state    <= S_ERROR;
                    load_error <= 1'b1;
                    busy       <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: normal load, sentinel, overflow, timeout,
// async reset and ignored-input cases with hand-computed expectations.
module tb_instr_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        wr_instruction;
    logic [31:0] data_instruction;
    logic [31:0] wr_addr;
    logic [5:0]  words_loaded;
    logic        busy;
    logic        load_done;
    logic        load_error;

    int nvec = 0;
    int nerr = 0;

    instr_loader #(
        .MEM_DEPTH(4), .START_ADDR(0), .END_WORD(32'hFFFF_FFFF), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_instruction(wr_instruction), .data_instruction(data_instruction),
        .wr_addr(wr_addr), .words_loaded(words_loaded), .busy(busy),
        .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    // Write log captured at negedge, where the memory would sample
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    int          nwr  = 0;
    int          wide = 0;
    logic        prev_wr = 1'b0;
    always @(negedge clk) begin
        if (wr_instruction && nwr < 64) begin
            log_addr[nwr] = wr_addr;
            log_data[nwr] = data_instruction;
        end
        if (wr_instruction) nwr++;
        if (wr_instruction && prev_wr) wide++;
        prev_wr = wr_instruction;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Last byte leaves the caller at the negedge right after it was sampled
    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        rx_valid = 1'b1; rx_data = w[23:16]; @(negedge clk);
        rx_data = w[15:8];  @(negedge clk);
        rx_data = w[7:0];   @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int base;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_wr",    32'(wr_instruction), 32'h0);
        chk("rst_data",  data_instruction,    32'h0);
        chk("rst_addr",  wr_addr,             32'h0);
        chk("rst_words", 32'(words_loaded),   32'h0);
        chk("rst_busy",  32'(busy),           32'h0);
        chk("rst_flags", {30'd0, load_done, load_error}, 32'h0);
        rst = 1'b1;

        // Bytes in IDLE are ignored; 3 words + sentinel, with a start pulse mid-word
        base = nwr;
        send_byte(8'hAA);
        send_byte(8'hBB);
        pulse_start();
        chk("t1_busy", 32'(busy), 32'h1);
        send_word(32'h2001_0008);
        send_byte(8'h24);
        send_byte(8'h02);
        chk("t1_addr_mid", wr_addr, 32'h1);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        send_word(32'h0022_1820);
        send_word(32'hFFFF_FFFF);
        @(negedge clk);
        chk("t1_nwr",   32'(nwr - base), 32'd3);
        chk("t1_a0",    log_addr[base],     32'd0);
        chk("t1_d0",    log_data[base],     32'h2001_0008);
        chk("t1_a1",    log_addr[base + 1], 32'd1);
        chk("t1_d1",    log_data[base + 1], 32'h2402_0004);
        chk("t1_a2",    log_addr[base + 2], 32'd2);
        chk("t1_d2",    log_data[base + 2], 32'h0022_1820);
        chk("t1_done",  32'(load_done),     32'h1);
        chk("t1_err",   32'(load_error),    32'h0);
        chk("t1_words", 32'(words_loaded),  32'd3);
        chk("t1_busy0", 32'(busy),          32'h0);

        // Sentinel first
        base = nwr;
        pulse_start();
        chk("t2_clr_done", 32'(load_done), 32'h0);
        send_word(32'hFFFF_FFFF);
        @(negedge clk);
        chk("t2_nwr",   32'(nwr - base),   32'd0);
        chk("t2_done",  32'(load_done),    32'h1);
        chk("t2_words", 32'(words_loaded), 32'd0);

        // Overflow at MEM_DEPTH=4
        base = nwr;
        pulse_start();
        for (int i = 0; i < 4; i++) send_word(32'h1000_0000 + 32'(i));
        chk("t3_err_early", 32'(load_error), 32'h0);
        send_word(32'h1000_0004);
        chk("t3_err",   32'(load_error), 32'h1);
        chk("t3_busy",  32'(busy),       32'h0);
        repeat (3) @(negedge clk);
        chk("t3_nwr",   32'(nwr - base),   32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_addr", log_addr[base + i], 32'(i));
            chk("t3_data", log_data[base + i], 32'h1000_0000 + 32'(i));
        end
        chk("t3_words", 32'(words_loaded), 32'd4);
        chk("t3_done",  32'(load_done),    32'h0);

        // Timeout 16 cycles after the 2nd byte of a partial word
        base = nwr;
        pulse_start();
        chk("t4_err_clr", 32'(load_error), 32'h0);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h12; @(negedge clk);
        rx_data = 8'h34; @(negedge clk);
        rx_valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("t4_err_15", 32'(load_error), 32'h0);
        @(negedge clk);
        chk("t4_err_16", 32'(load_error), 32'h1);
        chk("t4_nwr",    32'(nwr - base), 32'd0);
        base = nwr;
        pulse_start();
        send_word(32'hCAFE_0001);
        repeat (2) @(negedge clk);
        chk("t4_nwr2", 32'(nwr - base),  32'd1);
        chk("t4_addr", log_addr[base],   32'd0);
        chk("t4_data", log_data[base],   32'hCAFE_0001);
        send_word(32'hFFFF_FFFF);
        @(negedge clk);
        chk("t4_done", 32'(load_done), 32'h1);

        // Async reset mid-session
        pulse_start();
        send_word(32'h0BAD_0001);
        send_byte(8'h55);
        chk("t5_pre_words", 32'(words_loaded), 32'd1);
        base = nwr;
        #2 rst = 1'b0;
        #1;
        chk("t5_addr",  wr_addr,            32'h0);
        chk("t5_words", 32'(words_loaded),  32'h0);
        chk("t5_busy",  32'(busy),          32'h0);
        chk("t5_wr",    32'(wr_instruction), 32'h0);
        chk("t5_data",  data_instruction,   32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("t5_nwr0", 32'(nwr - base), 32'd0);
        pulse_start();
        send_word(32'h0000_0013);
        send_word(32'hFFFF_FFFF);
        @(negedge clk);
        chk("t5_nwr",  32'(nwr - base), 32'd1);
        chk("t5_waddr", log_addr[base], 32'd0);
        chk("t5_wdata", log_data[base], 32'h0000_0013);
        chk("t5_done", 32'(load_done), 32'h1);

        chk("strobe_width", 32'(wide), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Debug-unit stage directly upstream of the instruction memory; fills program memory before the pipeline runs.
- Consumes a UART receive byte stream and assembles 32-bit instruction words, MSB byte first.
- Drives `wr_instruction`, `data_instruction` and the write address into the instruction memory.
- Terminates on a sentinel word or on an error: overflow or inter-byte timeout.

Parameters:
- MEM_DEPTH, 32: number of instruction words the memory holds; maximum words accepted.
- START_ADDR, 0: word index of the first write.
- END_WORD, 32'hFFFF_FFFF: sentinel word that ends loading; never written to memory.
- TIMEOUT_CYCLES, 1000000: max clk cycles allowed between bytes of a partially assembled word.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-low.
- start  input  1  single-cycle request to begin a load session.
- rx_data  input  8  received UART byte.
- rx_valid  input  1  single-cycle strobe, rx_data valid.
- wr_instruction  output  1  instruction memory write strobe, one cycle per word.
- data_instruction  output  32  word to write.
- wr_addr  output  32  word index to write.
- words_loaded  output  6  count of words written this session.
- busy  output  1  session in progress (RECV or WRITE).
- load_done  output  1  sticky: sentinel received.
- load_error  output  1  sticky: overflow or timeout.

Behaviour:
- Reset:
  - rst low forces state IDLE immediately, independent of clk.
  - All outputs go to 0; byte count, accumulator and timeout counter go to 0.
  - Reset mid-session abandons the partial word; no write strobe is issued.
- Output timing:
  - All outputs are registered on posedge.
  - data_instruction and wr_addr are stable for the full cycle wr_instruction is high, so the memory samples them on the following negedge.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE:
  - busy=0; rx_valid is ignored.
  - start=1 -> RECV. On that edge: wr_addr=START_ADDR, words_loaded=0, byte_cnt=0, load_done=0, load_error=0.
- Byte accumulation (RECV and WRITE alike):
  - On rx_valid: acc <= {acc[23:0], rx_data}; byte_cnt++ (2-bit).
  - On the 4th byte, with assembled word w = {acc[23:0], rx_data}:
    - w == END_WORD -> DONE; no write.
    - else words_loaded == MEM_DEPTH -> ERROR; no write.
    - else data_instruction <= w -> WRITE.
  - byte_cnt wraps to 0 after the 4th byte.
- WRITE (exactly one cycle):
  - wr_instruction=1.
  - Next edge: wr_instruction=0, wr_addr++, words_loaded++, -> RECV.
  - A byte arriving during WRITE is accumulated normally. If it is the 4th byte, its completion is evaluated against the post-increment words_loaded in the following RECV cycle and no byte is lost.
- Timeout:
  - Counter clears on every rx_valid and whenever byte_cnt==0.
  - Counter increments each cycle in RECV while byte_cnt!=0.
  - Reaching TIMEOUT_CYCLES -> ERROR.
  - No timeout applies between whole words.
- DONE:
  - load_done=1 held, busy=0.
  - wr_addr and words_loaded hold their final values.
  - start -> new session, same as from IDLE.
- ERROR:
  - load_error=1 held, busy=0; outputs otherwise hold.
  - start -> new session.
- Ignored inputs:
  - start while busy is ignored.
  - rx_valid in IDLE, DONE or ERROR is ignored.
- Simultaneous start and rx_valid in IDLE/DONE/ERROR: start is taken and the byte is dropped.
- wr_addr width: 32 bits; it never exceeds START_ADDR+MEM_DEPTH-1 when wr_instruction is high.

Test Plan:
- Load 3 words then sentinel:
  - Stimulus: start; bytes 20 01 00 08, 24 02 00 04, 00 22 18 20, FF FF FF FF.
  - Required: three 1-cycle wr_instruction pulses, wr_addr 0/1/2 with data 0x20010008 / 0x24020004 / 0x00221820.
  - Required: load_done=1, words_loaded=3, busy=0.
- Sentinel first:
  - Stimulus: start, then FF FF FF FF.
  - Required: no write strobe, load_done=1, words_loaded=0.
- Overflow:
  - Stimulus: MEM_DEPTH=4; send 5 non-sentinel words.
  - Required: exactly 4 writes at addr 0..3; load_error=1 on the 5th word's last byte; no 5th strobe.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; send 2 bytes, then idle.
  - Required: load_error=1 16 cycles after the 2nd byte; no write.
  - Stimulus: start again, send a full word.
  - Required: written at addr 0.
- Async reset mid-session:
  - Stimulus: start; send 5 bytes; pull rst low between clock edges.
  - Required: all outputs 0 immediately.
  - Stimulus: release rst, start, send 1 word + sentinel.
  - Required: write at addr 0, load_done=1.
- Ignored inputs:
  - Stimulus: rx_valid bytes in IDLE, then start.
  - Required: they do not contribute to the first word.
  - Stimulus: start pulsed mid-session.
  - Required: wr_addr and byte_cnt unaffected.
